regfile_be: RTL and testbench

- Parametrised multi-port register file built from enabled, resettable storage words.
- Successor to the single enabled register. Adds:
  - configurable width, depth and read-port count;
  - per-byte write enables;
  - optional hardwired zero register;
  - optional write-to-read bypass.
- Sits in the datapath as the architectural register file.
- Serves NUM_RD combinational read ports and one synchronous write port.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_word.sv | 31 +++
 rtl/regfile_be.sv | 73 +++++++
 tb/tb_regfile_be.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the byte-enabled register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;

    localparam logic [DEF_DATA_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_word.sv
// One storage word with per-byte load enables and asynchronous active-low clear.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_BYTES  = BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BYTES-1:0]  be,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
        end else begin
            for (int b = 0; b < int'(NUM_BYTES); b++) begin
                if (be[b]) begin
                    word_q[8*b +: 8] <= d[8*b +: 8];
                end
            end
        end
    end

    assign q = word_q;

endmodule

// File: rtl/regfile_be.sv
// Multi-port register file: NUM_RD combinational reads, one byte-enabled synchronous write,
// optional hardwired zero entry and optional same-cycle write-to-read forwarding.
module regfile_be
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [ADDR_WIDTH-1:0]        wr_regnum,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_regnum,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;

    // A write is live only for an in-range entry that is not the hardwired zero.
    assign wr_ok = reset && enable && (32'(wr_regnum) < DEPTH) &&
                   !(ZERO_REG && (wr_regnum == '0));

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
        logic [NB-1:0] word_be;

        assign word_be = (wr_ok && (wr_regnum == ADDR_WIDTH'(i))) ? wr_be : '0;

        regfile_word #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_BYTES  (NB)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .be    (word_be),
            .d     (wr_data),
            .q     (mem[i])
        );
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] word;

        assign addr = rd_regnum[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            word = '0;
            if (reset && (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0))) begin
                word = mem[addr];
                // Forward the merged write value when reading the entry being written.
                if (BYPASS && wr_ok && (addr == wr_regnum)) begin
                    for (int b = 0; b < int'(NB); b++) begin
                        if (wr_be[b]) begin
                            word[8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = word;
    end

endmodule

// File: tb/tb_regfile_be.sv
// Bench for regfile_be: two instances (DEPTH=30 no bypass, DEPTH=32 with bypass) on shared
// stimulus, compared against an array-based model of the register file.
module tb_regfile_be;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  wr_regnum;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [9:0]  rd_regnum;
    logic [63:0] rd_data0;
    logic [63:0] rd_data1;

    int tests = 0;
    int fails = 0;

    logic [31:0] m [2][32];

    always #5 clk = ~clk;

    regfile_be #(
        .DATA_WIDTH (32),
        .DEPTH      (30),
        .ADDR_WIDTH (5),
        .NUM_RD     (2),
        .ZERO_REG   (1'b1),
        .BYPASS     (1'b0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_regnum (wr_regnum),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_regnum (rd_regnum),
        .rd_data   (rd_data0)
    );

    regfile_be #(
        .DATA_WIDTH (32),
        .DEPTH      (32),
        .ADDR_WIDTH (5),
        .NUM_RD     (2),
        .ZERO_REG   (1'b1),
        .BYPASS     (1'b1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_regnum (wr_regnum),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_regnum (rd_regnum),
        .rd_data   (rd_data1)
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 30 : 32;
    endfunction

    function automatic bit writable(input int d);
        return reset && enable && (int'(wr_regnum) < depth_of(d)) && (wr_regnum != 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input int d, input logic [4:0] a);
        if (!reset || int'(a) >= depth_of(d) || a == 0) return ZERO_WORD;
        if (d == 1 && writable(d) && a == wr_regnum) return merge(m[d][a]);
        return m[d][a];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) for (int i = 0; i < 32; i++) m[d][i] = '0;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) if (writable(d)) m[d][wr_regnum] = merge(m[d][wr_regnum]);
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] obs, exp;
                obs = (d == 0) ? rd_data0[k*32 +: 32] : rd_data1[k*32 +: 32];
                exp = model_rd(d, rd_regnum[k*5 +: 5]);
                tests++;
                assert (obs === exp) else begin
                    fails++;
                    $error("FAIL %s dut%0d port%0d: got %h expected %h", tag, d, k, obs, exp);
                end
            end
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [4:0] ra0, input logic [4:0] ra1);
        enable    = en;
        wr_regnum = wa;
        wr_data   = wd;
        wr_be     = be;
        rd_regnum = {ra1, ra0};
    endtask

    // Check before the edge, apply the write to the model at the edge, check after it.
    task automatic step(input string tag);
        #1 check_all({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1 check_all({tag, "_post"});
        @(negedge clk);
    endtask

    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        model_clear();
        #1 check_all({tag, "_rstlow"});
        @(posedge clk);
        model_edge();
        #1 check_all({tag, "_rstedge"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd7);
        #10 check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        step("release");

        drive(1'b1, 5'd2, 32'd88, 4'hF, 5'd2, 5'd2);
        step("wr88");
        drive(1'b0, 5'd2, 32'd89, 4'hF, 5'd2, 5'd2);
        step("hold88");

        drive(1'b1, 5'd5, 32'h11223344, 4'hF, 5'd5, 5'd2);
        step("r5_full");
        drive(1'b1, 5'd5, 32'hAABBCCDD, 4'b0101, 5'd5, 5'd2);
        step("r5_bytes");
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'h0, 5'd5, 5'd5);
        step("r5_be0");

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd5);
        step("r0_write");
        drive(1'b1, 5'd31, 32'h12345678, 4'hF, 5'd31, 5'd30);
        step("r31_write");

        drive(1'b1, 5'd4, 32'hCAFEF00D, 4'b0011, 5'd4, 5'd4);
        step("bypass_r4");
        drive(1'b1, 5'd4, 32'h0BADBEEF, 4'b1100, 5'd4, 5'd9);
        step("bypass_r9");

        drive(1'b1, 5'd2, 32'd5, 4'hF, 5'd2, 5'd4);
        step("r2_5");
        drive(1'b1, 5'd2, 32'd7, 4'hF, 5'd2, 5'd4);
        mid_reset("midrst");
        drive(1'b0, 5'd2, 32'd7, 4'hF, 5'd2, 5'd4);
        step("after_rst");
        drive(1'b1, 5'd2, 32'd7, 4'hF, 5'd2, 5'd4);
        step("r2_7");

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 4'($urandom),
                  5'($urandom), 5'($urandom));
            // Bias reads toward the write target so forwarding gets exercised.
            if ($urandom_range(0, 3) == 0) rd_regnum[4:0] = wr_regnum;
            if ($urandom_range(0, 59) == 0) mid_reset("rand_rst");
            else step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
